// File: rtl/ps2_key_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_pkg
// Shared constants for the PS/2 keyboard receive path.
//   - PS/2 prefix and controller/status byte values
//   - frame FSM state encoding (IDLE / SHIFT / CHECK)
//   - isStatusByte(): true for bytes that never reach the key event output
// ---------------------------------------------------------------------------
package ps2_key_decoder_pkg;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_E1     = 8'hE1;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERRF   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } frameState_t;

  // Controller/status bytes that must be dropped without touching the prefixes.
  function automatic logic isStatusByte(input logic [7:0] b);
    return (b == PS2_BAT)    || (b == PS2_ACK)  || (b == PS2_RESEND) ||
           (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERRF);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Bundles the PS/2 line inputs and the decoded key event outputs.
//   ps2_clk   : raw PS/2 clock line (idle high)
//   ps2_data  : raw PS/2 data line (idle high)
//   ps2_key   : [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   frame_err : one-ce-cycle pulse on a framing error or timeout
// master = side that drives the PS/2 lines (keyboard / bench)
// slave  = the decoder
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (output ps2_clk, output ps2_data, input ps2_key, input frame_err);
  modport slave  (input ps2_clk, input ps2_data, output ps2_key, output frame_err);
endinterface

// File: rtl/ps2_key_decoder_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Turns the raw PS/2 lines into received bytes.
// Synchronises both lines, glitch-filters the clock, and runs the 11-bit
// frame FSM (start, d0..d7, odd parity, stop) with a mid-frame timeout.
// Ports:
//   clock, reset    : system clock, async active-high reset
//   ce              : clock enable for everything except the synchronisers
//   i_ps2Clk/Data   : raw PS/2 lines
//   o_byte          : received byte, valid while o_byteValid is high
//   o_byteValid     : one ce-cycle strobe for a well-formed frame
//   o_frameErr      : one ce-cycle strobe for start/parity/stop error or timeout
// Both strobes are combinational and already qualified by ce.
// ---------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2048
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic [7:0] o_byte,
  output logic       o_byteValid,
  output logic       o_frameErr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    r_clkSync;
  logic [1:0]    r_dataSync;
  logic [FW-1:0] r_filtCnt;
  logic          r_filtLevel;
  frameState_t   r_state;
  frameState_t   w_stateNext;
  logic [3:0]    r_bitCnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_tcnt;

  logic w_clkS;
  logic w_dataS;
  logic w_filtFlip;
  logic w_fall;
  logic w_timeout;
  logic w_byteValid;
  logic w_frameErr;

  // Synchronisers run every clock so that ce gaps never widen metastability windows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], i_ps2Clk};
      r_dataSync <= {r_dataSync[0], i_ps2Data};
    end
  end

  assign w_clkS  = r_clkSync[1];
  assign w_dataS = r_dataSync[1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample;
  // any sample equal to the current level restarts the count.
  assign w_filtFlip = (w_clkS != r_filtLevel) && (r_filtCnt == FW'(FILTER_LEN - 1));
  assign w_fall     = ce && w_filtFlip && r_filtLevel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_filtCnt   <= '0;
      r_filtLevel <= 1'b1;
    end else if (ce) begin
      if (w_clkS == r_filtLevel) begin
        r_filtCnt <= '0;
      end else if (w_filtFlip) begin
        r_filtLevel <= w_clkS;
        r_filtCnt   <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  assign w_timeout = (r_tcnt == TW'(TIMEOUT - 1));

  // Frame FSM next-state and strobes. A fall wins over a coincident timeout.
  always_comb begin
    w_stateNext = r_state;
    w_byteValid = 1'b0;
    w_frameErr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          if (!w_dataS) w_stateNext = ST_SHIFT;
          else          w_frameErr  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          if (r_bitCnt == 4'd9) w_stateNext = ST_CHECK;
        end else if (ce && w_timeout) begin
          w_frameErr  = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (ce) begin
          w_stateNext = ST_IDLE;
          if ((^r_shift[8:0]) && r_shift[9]) w_byteValid = 1'b1;
          else                               w_frameErr  = 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // State register plus shift register, bit counter and timeout counter.
  // Bits arrive LSB first, so shifting right leaves d0 in r_shift[0] and stop in r_shift[9].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_tcnt   <= '0;
    end else if (ce) begin
      r_state <= w_stateNext;
      if (w_fall) begin
        r_tcnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_fall && (r_state == ST_IDLE)) begin
        r_bitCnt <= '0;
      end else if (w_fall && (r_state == ST_SHIFT)) begin
        r_shift  <= {w_dataS, r_shift[9:1]};
        r_bitCnt <= r_bitCnt + 1'b1;
      end
    end
  end

  assign o_byte      = r_shift[7:0];
  assign o_byteValid = w_byteValid;
  assign o_frameErr  = w_frameErr;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Decodes PS/2 keyboard bytes into 11-bit key events in MiSTer ps2_key format.
// Bit 10 toggles once per complete make/break code; bits 9:0 are stable when it does.
// Handles E0 (extended) and F0 (break) prefixes, swallows the 7-byte tail of the
// E1 pause sequence, and drops controller/status bytes.
// Ports:
//   clock : system clock
//   reset : async active-high reset
//   ce    : clock enable
//   ps2   : slave side of ps2_key_decoder_if (ps2_clk, ps2_data in;
//           ps2_key, frame_err out)
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2048
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ce,
  ps2_key_decoder_if.slave ps2
);

  logic [7:0]  w_byte;
  logic        w_byteValid;
  logic        w_frameErr;
  logic [10:0] r_key;
  logic        r_frameErr;
  logic        r_ext;
  logic        r_brk;
  logic [2:0]  r_skip;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_frameRx (
    .clock       (clock),
    .reset       (reset),
    .ce          (ce),
    .i_ps2Clk    (ps2.ps2_clk),
    .i_ps2Data   (ps2.ps2_data),
    .o_byte      (w_byte),
    .o_byteValid (w_byteValid),
    .o_frameErr  (w_frameErr)
  );

  // Prefix tracking and key event register. An error drops any pending prefix
  // so it cannot attach to the next code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key      <= '0;
      r_frameErr <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_skip     <= '0;
    end else if (ce) begin
      r_frameErr <= w_frameErr;
      if (w_frameErr) begin
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
        r_skip <= '0;
      end else if (w_byteValid) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (w_byte == PS2_E1) begin
          r_skip <= 3'd7;
        end else if (w_byte == PS2_E0) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_F0) begin
          r_brk <= 1'b1;
        end else if (!isStatusByte(w_byte)) begin
          r_key <= {~r_key[10], ~r_brk, r_ext, w_byte};
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign ps2.ps2_key   = r_key;
  assign ps2.frame_err = r_frameErr;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Drives PS/2 frames into ps2_key_decoder and checks the key events and
// error pulses against expectations kept in a queue and counters.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2048;
  localparam int HALF       = 16;
  localparam int GAP        = 40;
  localparam int NVEC       = 21;

  typedef struct {
    logic [7:0] data;
    bit         badPar;
    bit         badStop;
    bit         expEvent;
    logic [9:0] expKey;
    bit         expErr;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic ce;
  int   ceCnt = 0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .ps2   (bus)
  );

  always #5 clock = ~clock;

  // ce is high three clocks out of four, so every freeze path gets exercised.
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clock);
      ceCnt = ceCnt + 1;
      ce = ((ceCnt % 4) != 3);
    end
  end

  logic [9:0] expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   errSeen     = 0;
  int   errExp      = 0;
  bit   monEn       = 1'b0;
  logic prevToggle  = 1'b0;
  logic prevErr     = 1'b0;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Watches the event toggle and the error pulse; each toggle is matched against the queue.
  always @(negedge clock) begin
    if (monEn) begin
      if (bus.ps2_key[10] !== prevToggle) begin
        prevToggle = bus.ps2_key[10];
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", {22'd0, bus.ps2_key[9:0]}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("event_key", {22'd0, bus.ps2_key[9:0]}, {22'd0, expQ.pop_front()});
        end
      end
      if (bus.frame_err && !prevErr) errSeen = errSeen + 1;
      prevErr = bus.frame_err;
    end
  end

  task automatic waitCe(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clock); while (!ce);
    end
  endtask

  // Sends nBits of a frame; data changes while ps2_clk is high. glitchAt inserts
  // a 3-tick low pulse in the high phase before that bit.
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop,
                               input int nBits, input int glitchAt);
    logic [10:0] bits;
    bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int k = 0; k < nBits; k++) begin
      bus.ps2_data = bits[k];
      if (k == glitchAt) begin
        waitCe(HALF / 2);
        bus.ps2_clk = 1'b0;
        waitCe(3);
        bus.ps2_clk = 1'b1;
        waitCe(HALF / 2);
      end else begin
        waitCe(HALF);
      end
      bus.ps2_clk = 1'b0;
      waitCe(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    waitCe(HALF);
  endtask

  task automatic settleAndCheck(input string name);
    waitCe(GAP);
    @(negedge clock);
    checkOutput({name, "_pending"}, expQ.size(), 0);
    checkOutput({name, "_errcount"}, errSeen, errExp);
    expQ.delete();
    errSeen = errExp;
  endtask

  initial begin
    logic [10:0] savedKey;

    vecs[0]  = '{8'h1C, 0, 0, 1, {2'b10, 8'h1C}, 0};
    vecs[1]  = '{8'hF0, 0, 0, 0, 10'h000,        0};
    vecs[2]  = '{8'h1C, 0, 0, 1, {2'b00, 8'h1C}, 0};
    vecs[3]  = '{8'hE0, 0, 0, 0, 10'h000,        0};
    vecs[4]  = '{8'hF0, 0, 0, 0, 10'h000,        0};
    vecs[5]  = '{8'h75, 0, 0, 1, {2'b01, 8'h75}, 0};
    vecs[6]  = '{8'h1C, 0, 0, 1, {2'b10, 8'h1C}, 0};
    vecs[7]  = '{8'h1C, 1, 0, 0, 10'h000,        1};
    vecs[8]  = '{8'hE0, 0, 1, 0, 10'h000,        1};
    vecs[9]  = '{8'h74, 0, 0, 1, {2'b10, 8'h74}, 0};
    vecs[10] = '{8'hE1, 0, 0, 0, 10'h000,        0};
    vecs[11] = '{8'h14, 0, 0, 0, 10'h000,        0};
    vecs[12] = '{8'h77, 0, 0, 0, 10'h000,        0};
    vecs[13] = '{8'hE1, 0, 0, 0, 10'h000,        0};
    vecs[14] = '{8'hF0, 0, 0, 0, 10'h000,        0};
    vecs[15] = '{8'h14, 0, 0, 0, 10'h000,        0};
    vecs[16] = '{8'hF0, 0, 0, 0, 10'h000,        0};
    vecs[17] = '{8'h77, 0, 0, 0, 10'h000,        0};
    vecs[18] = '{8'hAA, 0, 0, 0, 10'h000,        0};
    vecs[19] = '{8'hFA, 0, 0, 0, 10'h000,        0};
    vecs[20] = '{8'h16, 0, 0, 1, {2'b10, 8'h16}, 0};

    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_key", {21'd0, bus.ps2_key}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.frame_err}, 32'd0);
    prevToggle = 1'b0;
    prevErr    = 1'b0;
    monEn      = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].expEvent) expQ.push_back(vecs[i].expKey);
      if (vecs[i].expErr) errExp = errExp + 1;
      applyStimulus(vecs[i].data, vecs[i].badPar, vecs[i].badStop, 11, -1);
      settleAndCheck($sformatf("vec%0d", i));
    end

    // Partial frame abandoned with ps2_clk idle: timeout must abort it.
    savedKey = bus.ps2_key;
    applyStimulus(8'h29, 0, 0, 4, -1);
    waitCe(TIMEOUT + 100);
    errExp = errExp + 1;
    settleAndCheck("timeout");
    checkOutput("timeout_key", {21'd0, bus.ps2_key}, {21'd0, savedKey});

    expQ.push_back({2'b10, 8'h29});
    applyStimulus(8'h29, 0, 0, 11, -1);
    settleAndCheck("after_timeout");
    checkOutput("after_timeout_key", {21'd0, bus.ps2_key}, {21'd0, ~savedKey[10], 2'b10, 8'h29});

    // Short low glitch before d3 must not count as a bit.
    expQ.push_back({2'b10, 8'h31});
    applyStimulus(8'h31, 0, 0, 11, 4);
    settleAndCheck("glitch");

    // Reset in the middle of a frame.
    applyStimulus(8'h45, 0, 0, 5, -1);
    monEn = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset_key", {21'd0, bus.ps2_key}, 32'd0);
    prevToggle = 1'b0;
    prevErr    = 1'b0;
    errSeen    = 0;
    errExp     = 0;
    monEn      = 1'b1;
    waitCe(TIMEOUT + 100);
    @(negedge clock);
    checkOutput("midreset_noerr", errSeen, 0);
    checkOutput("midreset_key_hold", {21'd0, bus.ps2_key}, 32'd0);

    expQ.push_back({2'b10, 8'h1C});
    applyStimulus(8'h1C, 0, 0, 11, -1);
    settleAndCheck("after_reset");
    checkOutput("after_reset_key", {21'd0, bus.ps2_key}, {21'd0, 3'b110, 8'h1C});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
